spi_slave_pattern_checker: RTL and testbench
============================================

# spi_slave_pattern_checker

SPI slave (target) endpoint for the board-level SPI link test. Oversamples an external master's SCLK/MOSI/CS_n in the `clk` domain and supports all four CPOL/CPHA modes. Each received byte is checked against an incrementing pattern starting at 0x00, and the slave returns its own incrementing pattern on MISO. After a fixed number of bytes it reports frame completion and a pass/fail status.

## Interface
Parameters:
- `BYTES_PER_FRAME`, default 64: bytes per test frame; legal range 1..255.
- `SYNC_STAGES`, default 2: synchronizer depth on `spi_sclk`, `spi_mosi` and `spi_cs_n`; minimum 2.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `spi_cs_n`  in  1  chip select from master, active-low.
- `spi_sclk`  in  1  SPI clock from master.
- `spi_mosi`  in  1  master-out data.
- `spi_miso`  out  1  slave-out data; 1 when not selected.
- `mode_select_CPHA`  in  1  clock phase; latched at frame/byte start.
- `mode_select_CPOL`  in  1  clock idle polarity; latched at frame/byte start.
- `rx_byte`  out  8  last completed received byte.
- `rx_valid`  out  1  one-`clk` pulse when `rx_byte` updates.
- `byte_count`  out  8  completed bytes this frame.
- `match_count`  out  8  received bytes that equalled the expected pattern.
- `xfer_done`  out  1  high once `byte_count == BYTES_PER_FRAME`.
- `receive_status`  out  1  high when done and `match_count == BYTES_PER_FRAME`.

## Operation
- Inputs pass through `SYNC_STAGES` flops. An extra flop on the synchronized SCLK gives rise/fall detect.
- Leading edge is rising when CPOL=0 and falling when CPOL=1. Trailing edge is the opposite.
- Sample edge: leading edge when CPHA=0, trailing edge when CPHA=1. Shift edge is the other edge.
- States:
  - IDLE → SELECT on synchronized CS_n falling.
  - SELECT → IDLE on CS_n rising.
  - Any state → DONE when `byte_count` reaches `BYTES_PER_FRAME`.
  - DONE is sticky until `rst_n`.
- In DONE, `spi_miso` = 1 and SCLK is ignored.
- On entering SELECT:
  - Latch CPOL/CPHA.
  - Clear the 3-bit bit counter.
  - Load the tx shift register with `tx_pattern`.
  - Drive its MSB on `spi_miso` immediately (required for CPHA=0).
- Sample edge: shift `spi_mosi` into rx shift register MSB-first and increment the bit counter.
- Shift edge: shift the tx register left and drive the next bit.
  - For CPHA=1, the first shift edge (the leading edge) drives the MSB and does not shift.
- On the 8th sample edge:
  - `rx_byte` ← assembled byte; pulse `rx_valid`.
  - If `rx_byte == byte_count`, increment `match_count`.
  - Increment `byte_count` and `tx_pattern`.
  - Clear the bit counter and reload the tx register with the new `tx_pattern`.
- `tx_pattern` resets to 0x00 and increments by 1 mod 256.
- CS_n rising mid-byte: discard partial bits and clear the bit counter. Counters and `tx_pattern` are retained.
- CS_n rising in the same cycle as the 8th sample edge: the byte completes first, then the block returns to IDLE.
- Mode inputs that change while selected are ignored until the next SELECT entry.

## Timing
- Reset values: `spi_miso`=1, `rx_byte`=0x00, `rx_valid`=0, `byte_count`=0, `match_count`=0, `xfer_done`=0, `receive_status`=0.
- Internal state resets to IDLE with `tx_pattern`=0x00.
- Input-to-edge-detect latency: `SYNC_STAGES`+1 `clk` after the pin transition.
- `rx_valid`, `rx_byte` and the counters update 1 `clk` after the detected 8th sample edge.
- `spi_miso` updates 1 `clk` after a detected shift edge, i.e. `SYNC_STAGES`+2 `clk` after the pin edge.
- SCLK high and low phases must each last at least `2*SYNC_STAGES`+2 `clk` cycles.
- CS_n setup to first SCLK edge: at least `SYNC_STAGES`+3 `clk`.
- `xfer_done` asserts in the same cycle `byte_count` reaches `BYTES_PER_FRAME`.
- `receive_status` is registered and follows `xfer_done` by 1 `clk`.
- `rst_n` mid-frame returns all state to reset values at once.

## Configuration
- `SPI_SLAVE_ECHO_EN` defined:
  - The tx register reloads with the previously received byte instead of `tx_pattern`.
  - The first byte of a frame transmits 0xFF.
- `SPI_SLAVE_ECHO_EN` undefined: the incrementing pattern is transmitted as described above.

## Test plan
- Mode 0, 64-byte frame, master sends 0x00..0x3F → 64 `rx_valid` pulses, `rx_byte` 0x00..0x3F, `byte_count`=64, `match_count`=64, `xfer_done`=1, `receive_status`=1; master receives 0x00..0x3F on MISO.
- Modes 1, 2 and 3 (CPHA/CPOL sweep), same stimulus → identical results for each mode; SCLK idle level matches CPOL.
- Byte 5 corrupted to 0xAA → `match_count`=63, `xfer_done`=1, `receive_status`=0.
- CS_n deasserted after 4 bits of byte 3, then reselected and bytes 3..63 sent → the partial byte is dropped, no `rx_valid` for it, and the frame completes with `receive_status`=1.
- `rst_n` pulsed after 10 bytes → all outputs return to reset values, `spi_miso`=1, next frame starts with expected value 0x00 and tx 0x00.
- `SPI_SLAVE_ECHO_EN` build, master sends 0x10, 0x20, 0x30 → MISO returns 0xFF, 0x10, 0x20.

Source files
------------

// File: rtl/spi_slave_pattern_checker_if.sv
// SPI bus bundle between a link-test master and the pattern-checking slave.
// Signal names follow the board-level pin names.
interface spi_slave_pattern_checker_if;
  logic spi_cs_n;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_cs_n, output spi_sclk, output spi_mosi, input spi_miso);
  modport slave  (input spi_cs_n, input spi_sclk, input spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_slave_pattern_checker.sv
// SPI slave endpoint for the board-level link test.
// - Oversamples SCLK/MOSI/CS_n in the clk domain and supports all four CPOL/CPHA modes.
// - Checks received bytes against an incrementing pattern and returns its own pattern on MISO.
// - Build option SPI_SLAVE_ECHO_EN: MISO echoes the previously received byte
//   (0xFF for the first byte of a frame) instead of the incrementing pattern.
module spi_slave_pattern_checker #(
  parameter int BYTES_PER_FRAME = 64,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  spi_slave_pattern_checker_if.slave   spi,
  input  logic                         mode_select_CPHA,
  input  logic                         mode_select_CPOL,
  output logic [7:0]                   rx_byte,
  output logic                         rx_valid,
  output logic [7:0]                   byte_count,
  output logic [7:0]                   match_count,
  output logic                         xfer_done,
  output logic                         receive_status
);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_SELECT = 2'b01;
  localparam logic [1:0] ST_DONE   = 2'b10;

  localparam logic [7:0] BPF8 = 8'(BYTES_PER_FRAME);

  // Synchronizer chains and edge-detect history
  logic [SYNC_STAGES-1:0] cs_sync_reg;
  logic [SYNC_STAGES-1:0] sclk_sync_reg;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic                   cs_prev_reg;
  logic                   sclk_prev_reg;

  // Control and datapath state
  logic [1:0] state_reg;
  logic       cpol_reg;
  logic       cpha_reg;
  logic [2:0] bit_cnt_reg;
  logic [6:0] rx_shift_reg;
  logic [7:0] tx_shift_reg;
  logic       first_shift_reg;
  logic [7:0] tx_pattern_reg;
  logic       miso_reg;
  logic [7:0] rx_byte_reg;
  logic       rx_valid_reg;
  logic [7:0] byte_count_reg;
  logic [7:0] match_count_reg;
  logic       xfer_done_reg;
  logic       receive_status_reg;

  // Derived strobes
  logic       cs_s;
  logic       sclk_s;
  logic       mosi_s;
  logic       cs_fall;
  logic       cs_rise;
  logic       sclk_rise;
  logic       sclk_fall;
  logic       lead_edge;
  logic       trail_edge;
  logic       sample_edge;
  logic       shift_edge;
  logic       byte_complete;
  logic       last_byte;
  logic [7:0] rx_assembled;
  logic [7:0] entry_reload;
  logic [7:0] byte_reload;

  // Bring the asynchronous SPI pins into the clk domain; CS_n idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_reg   <= '1;
      sclk_sync_reg <= '0;
      mosi_sync_reg <= '0;
      cs_prev_reg   <= 1'b1;
      sclk_prev_reg <= 1'b0;
    end else begin
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], spi.spi_cs_n};
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], spi.spi_sclk};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spi.spi_mosi};
      cs_prev_reg   <= cs_s;
      sclk_prev_reg <= sclk_s;
    end
  end

  assign cs_s   = cs_sync_reg[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

  assign cs_fall   = cs_prev_reg & ~cs_s;
  assign cs_rise   = ~cs_prev_reg & cs_s;
  assign sclk_rise = ~sclk_prev_reg & sclk_s;
  assign sclk_fall = sclk_prev_reg & ~sclk_s;

  // Edge roles use the mode latched at SELECT entry, never the live inputs
  assign lead_edge   = cpol_reg ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_reg ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_reg ? trail_edge : lead_edge;
  assign shift_edge  = cpha_reg ? lead_edge : trail_edge;

  assign rx_assembled  = {rx_shift_reg, mosi_s};
  assign byte_complete = sample_edge && (bit_cnt_reg == 3'd7);
  assign last_byte     = (byte_count_reg == BPF8 - 8'd1);

`ifdef SPI_SLAVE_ECHO_EN
  assign entry_reload = (byte_count_reg == 8'd0) ? 8'hFF : rx_byte_reg;
  assign byte_reload  = rx_assembled;
`else
  assign entry_reload = tx_pattern_reg;
  assign byte_reload  = tx_pattern_reg + 8'd1;
`endif

  // Frame FSM, shift registers, counters and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg          <= ST_IDLE;
      cpol_reg           <= 1'b0;
      cpha_reg           <= 1'b0;
      bit_cnt_reg        <= 3'd0;
      rx_shift_reg       <= 7'd0;
      tx_shift_reg       <= 8'd0;
      first_shift_reg    <= 1'b0;
      tx_pattern_reg     <= 8'd0;
      miso_reg           <= 1'b1;
      rx_byte_reg        <= 8'd0;
      rx_valid_reg       <= 1'b0;
      byte_count_reg     <= 8'd0;
      match_count_reg    <= 8'd0;
      xfer_done_reg      <= 1'b0;
      receive_status_reg <= 1'b0;
    end else begin
      rx_valid_reg       <= 1'b0;
      receive_status_reg <= xfer_done_reg && (match_count_reg == BPF8);
      case (state_reg)
        ST_IDLE: begin
          miso_reg <= 1'b1;
          if (cs_fall) begin
            state_reg       <= ST_SELECT;
            cpol_reg        <= mode_select_CPOL;
            cpha_reg        <= mode_select_CPHA;
            bit_cnt_reg     <= 3'd0;
            tx_shift_reg    <= entry_reload;
            miso_reg        <= entry_reload[7];
            // CPHA=1 re-drives the MSB on the first leading edge instead of shifting
            first_shift_reg <= mode_select_CPHA;
          end
        end
        ST_SELECT: begin
          if (shift_edge) begin
            if (first_shift_reg) begin
              first_shift_reg <= 1'b0;
              miso_reg        <= tx_shift_reg[7];
            end else begin
              tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
              miso_reg     <= tx_shift_reg[6];
            end
          end
          if (sample_edge) begin
            rx_shift_reg <= rx_assembled[6:0];
            bit_cnt_reg  <= bit_cnt_reg + 3'd1;
          end
          if (byte_complete) begin
            rx_byte_reg    <= rx_assembled;
            rx_valid_reg   <= 1'b1;
            byte_count_reg <= byte_count_reg + 8'd1;
            tx_pattern_reg <= tx_pattern_reg + 8'd1;
            if (rx_assembled == byte_count_reg) begin
              match_count_reg <= match_count_reg + 8'd1;
            end
            // MISO keeps bit 0 until the next shift edge, which then drives the new MSB
            tx_shift_reg    <= byte_reload;
            first_shift_reg <= 1'b1;
          end
          // A completing byte is counted before a coincident deselect takes effect
          if (byte_complete && last_byte) begin
            state_reg     <= ST_DONE;
            xfer_done_reg <= 1'b1;
            miso_reg      <= 1'b1;
          end else if (cs_rise) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= 3'd0;
            miso_reg    <= 1'b1;
          end
        end
        ST_DONE: begin
          miso_reg <= 1'b1;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign spi.spi_miso   = miso_reg;
  assign rx_byte        = rx_byte_reg;
  assign rx_valid       = rx_valid_reg;
  assign byte_count     = byte_count_reg;
  assign match_count    = match_count_reg;
  assign xfer_done      = xfer_done_reg;
  assign receive_status = receive_status_reg;

endmodule

// File: tb/tb_spi_slave_pattern_checker.sv
// Scoreboard bench for spi_slave_pattern_checker: a bit-banged SPI master
// pushes expected received bytes into a queue, and a monitor pops and
// compares them on every rx_valid pulse.
module tb_spi_slave_pattern_checker;
  localparam int BPF  = 64;
  localparam int HALF = 7;

  typedef struct packed {
    logic [7:0] rx;
    logic [7:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpha = 1'b0;
  logic       cpol = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] byte_count;
  logic [7:0] match_count;
  logic       xfer_done;
  logic       receive_status;

  int checks = 0;
  int errors = 0;

  exp_t       exp_q[$];
  logic [7:0] m_cnt = 8'd0;
  logic [7:0] m_match = 8'd0;
  logic [7:0] m_prev = 8'd0;

  spi_slave_pattern_checker_if spi ();

  spi_slave_pattern_checker #(.BYTES_PER_FRAME(BPF), .SYNC_STAGES(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .spi              (spi),
    .mode_select_CPHA (cpha),
    .mode_select_CPOL (cpol),
    .rx_byte          (rx_byte),
    .rx_valid         (rx_valid),
    .byte_count       (byte_count),
    .match_count      (match_count),
    .xfer_done        (xfer_done),
    .receive_status   (receive_status)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected MISO byte for the next transfer
  function automatic logic [7:0] exp_miso();
`ifdef SPI_SLAVE_ECHO_EN
    return (m_cnt == 8'd0) ? 8'hFF : m_prev;
`else
    return m_cnt;
`endif
  endfunction

  // Monitor: compare every rx_valid pulse against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rx_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rx_valid got=%02h required=no_pulse", rx_byte);
        end else begin
          e = exp_q.pop_front();
          check("rx_byte", rx_byte, e.rx);
          check("byte_count", byte_count, e.cnt);
          check("xfer_done_at_rx", xfer_done, e.cnt == 8'(BPF));
          $display("rx byte=%02h count=%0d expected=%02h", rx_byte, byte_count, e.rx);
        end
      end
    end
  end

  // Clock out nbits of d MSB-first in the current mode; got collects MISO
  task automatic spi_bits(input logic [7:0] d, input int nbits, output logic [7:0] got);
    got = 8'd0;
    for (int b = 7; b >= 8 - nbits; b--) begin
      if (!cpha) begin
        spi.spi_mosi = d[b];
        repeat (HALF) @(negedge clk);
        spi.spi_sclk = ~cpol;
        got[b] = spi.spi_miso;
        repeat (HALF) @(negedge clk);
        spi.spi_sclk = cpol;
      end else begin
        spi.spi_sclk = ~cpol;
        spi.spi_mosi = d[b];
        repeat (HALF) @(negedge clk);
        spi.spi_sclk = cpol;
        got[b] = spi.spi_miso;
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    exp_t       e;
    logic [7:0] got;
    logic [7:0] want;
    want  = exp_miso();
    e.rx  = d;
    e.cnt = m_cnt + 8'd1;
    exp_q.push_back(e);
    spi_bits(d, 8, got);
    check("miso_byte", got, want);
    $display("xfer mode=%0d mosi=%02h miso=%02h expected_miso=%02h", {cpol, cpha}, d, got, want);
    if (d == m_cnt) m_match = m_match + 8'd1;
    m_cnt  = m_cnt + 8'd1;
    m_prev = d;
  endtask

  task automatic do_reset();
    check("queue_drained_before_reset", exp_q.size(), 0);
    spi.spi_cs_n = 1'b1;
    spi.spi_sclk = cpol;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_cnt = 8'd0;
    m_match = 8'd0;
    m_prev = 8'd0;
    repeat (5) @(negedge clk);
  endtask

  task automatic select();
    spi.spi_sclk = cpol;
    repeat (4) @(negedge clk);
    spi.spi_cs_n = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic deselect();
    spi.spi_cs_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic check_final(input string tag);
    logic done_exp;
    done_exp = (m_cnt == 8'(BPF));
    check({tag, "_byte_count"}, byte_count, m_cnt);
    check({tag, "_match_count"}, match_count, m_match);
    check({tag, "_xfer_done"}, xfer_done, done_exp);
    check({tag, "_receive_status"}, receive_status, done_exp && (m_match == 8'(BPF)));
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_miso_idle"}, spi.spi_miso, 1'b1);
    $display("frame %s bytes=%0d matches=%0d done=%0b status=%0b", tag, byte_count, match_count,
             xfer_done, receive_status);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_miso"}, spi.spi_miso, 1'b1);
    check({tag, "_rx_byte"}, rx_byte, 8'h00);
    check({tag, "_rx_valid"}, rx_valid, 1'b0);
    check({tag, "_byte_count"}, byte_count, 8'd0);
    check({tag, "_match_count"}, match_count, 8'd0);
    check({tag, "_xfer_done"}, xfer_done, 1'b0);
    check({tag, "_receive_status"}, receive_status, 1'b0);
  endtask

  // Global watchdog so the run always terminates
  initial begin
    #3ms;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] junk;
    spi.spi_cs_n = 1'b1;
    spi.spi_sclk = 1'b0;
    spi.spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Full 64-byte frame in each of the four SPI modes
    for (int m = 0; m < 4; m++) begin
      cpol = m[1];
      cpha = m[0];
      do_reset();
      select();
      for (int i = 0; i < BPF; i++) send_byte(8'(i));
      deselect();
      check_final($sformatf("mode%0d", m));
    end

    // Byte 5 corrupted
    cpol = 1'b0;
    cpha = 1'b0;
    do_reset();
    select();
    for (int i = 0; i < BPF; i++) send_byte((i == 5) ? 8'hAA : 8'(i));
    deselect();
    check_final("corrupt");

    // Deselect after 4 bits of byte 3, then resume from byte 3
    cpol = 1'b1;
    cpha = 1'b1;
    do_reset();
    select();
    for (int i = 0; i < 3; i++) send_byte(8'(i));
    spi_bits(8'h03, 4, junk);
    deselect();
    check("partial_byte_count", byte_count, 8'd3);
    select();
    for (int i = 3; i < BPF; i++) send_byte(8'(i));
    deselect();
    check_final("partial");

    // Asynchronous reset after 10 bytes, then a fresh short frame
    cpol = 1'b0;
    cpha = 1'b1;
    do_reset();
    select();
    for (int i = 0; i < 10; i++) send_byte(8'(i));
    repeat (4) @(negedge clk);
    check("pre_reset_byte_count", byte_count, 8'd10);
    rst_n = 1'b0;
    #1;
    check_reset_values("midframe_reset");
    @(negedge clk);
    spi.spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_cnt = 8'd0;
    m_match = 8'd0;
    m_prev = 8'd0;
    repeat (5) @(negedge clk);
    select();
    for (int i = 0; i < 3; i++) send_byte(8'(i));
    deselect();
    check_final("after_reset");

    // Short frame of non-pattern data (echo stimulus)
    cpol = 1'b0;
    cpha = 1'b0;
    do_reset();
    select();
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h30);
    deselect();
    check_final("echo");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
